vexp_sequencer: RTL and testbench

- Controller that takes one packed vector of bf16 elements and feeds the elements one at a time into the shared single-lane vector exp unit.
- Uses the unit's valid/ready handshake on both its operand side and its result side.
- Collects results in element order and returns the full result vector over a request/response handshake.
- Sits between the vector issue stage and the vexp datapath; limits outstanding operations with a credit counter.

---
 rtl/vexp_sequencer.sv | 119 +++++++++++
 tb/tb_vexp_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vexp_sequencer.sv
// rtl/vexp_sequencer.sv - feeds a packed bf16 vector one element at a time through the shared vexp unit
//
// Ports:
//   CLK, nRST                    clock, asynchronous active-low reset
//   req_valid/req_ready          vector request handshake; req_vec packed operands, req_len active count
//   resp_valid/resp_ready        result vector handshake; resp_vec packed results (inactive slots are 0)
//   busy                         sequencer is not idle
//   exp_operand/exp_valid_in/exp_ready_in     operand side of the vexp unit
//   exp_result/exp_valid_out/exp_ready_out    result side of the vexp unit
module vexp_sequencer #(
    parameter int NUM_ELEMS    = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_INFLIGHT = 4,
    parameter int IDX_W        = $clog2(NUM_ELEMS)
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [NUM_ELEMS*DATA_W-1:0] req_vec,
    input  logic [IDX_W:0]              req_len,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [NUM_ELEMS*DATA_W-1:0] resp_vec,
    output logic                        busy,
    output logic [DATA_W-1:0]           exp_operand,
    output logic                        exp_valid_in,
    input  logic                        exp_ready_in,
    input  logic [DATA_W-1:0]           exp_result,
    input  logic                        exp_valid_out,
    output logic                        exp_ready_out
);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(NUM_ELEMS);
    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  issue_cnt, ret_cnt, len_q;
    logic [CNT_W-1:0]  outstanding, req_len_clamped;
    logic [DATA_W-1:0] op_mem  [NUM_ELEMS];
    logic [DATA_W-1:0] res_mem [NUM_ELEMS];
    logic              accept, issue_ok, ret_ok, issue_fire, ret_fire;

    assign outstanding     = issue_cnt - ret_cnt;
    assign req_len_clamped = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    assign accept          = (state == S_IDLE) && req_valid;
    // issue_ok only falls through issue_fire or a full credit window, and the window
    // can only shrink by issuing, so an offered operand stays offered until taken.
    assign issue_ok        = (state == S_RUN) && (issue_cnt < len_q) && (outstanding < MAX_OUT);
    // Results arriving with nothing outstanding are never acknowledged and thus dropped.
    assign ret_ok          = (state == S_RUN) && (outstanding != '0);
    assign issue_fire      = issue_ok && exp_ready_in;
    assign ret_fire        = ret_ok && exp_valid_out;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req_valid) next_state = (req_len_clamped == '0) ? S_DONE : S_RUN;
            S_RUN:  if (ret_fire && ((ret_cnt + ONE) == len_q)) next_state = S_DONE;
            S_DONE: if (resp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
            len_q     <= '0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                op_mem[i]  <= '0;
                res_mem[i] <= '0;
            end
        end else if (accept) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
            len_q     <= req_len_clamped;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                op_mem[i]  <= req_vec[i*DATA_W +: DATA_W];
                res_mem[i] <= '0;
            end
        end else begin
            if (issue_fire) begin
                issue_cnt <= issue_cnt + ONE;
            end
            // The unit returns in order, so ret_cnt is the slot of the arriving result.
            if (ret_fire) begin
                res_mem[ret_cnt[IDX_W-1:0]] <= exp_result;
                ret_cnt                     <= ret_cnt + ONE;
            end
        end
    end

    always_comb begin
        req_ready     = (state == S_IDLE);
        resp_valid    = (state == S_DONE);
        busy          = (state != S_IDLE);
        exp_valid_in  = issue_ok;
        exp_operand   = issue_ok ? op_mem[issue_cnt[IDX_W-1:0]] : '0;
        exp_ready_out = ret_ok;
        resp_vec      = '0;
        if (state == S_DONE) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                resp_vec[i*DATA_W +: DATA_W] = res_mem[i];
            end
        end
    end
endmodule

// File: tb/tb_vexp_sequencer.sv
// tb/tb_vexp_sequencer.sv - randomized scoreboard bench for vexp_sequencer
module tb_vexp_sequencer;
    localparam int NE = 16;
    localparam int DW = 16;
    localparam int VW = NE * DW;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [VW-1:0] req_vec = '0;
    logic [4:0]    req_len = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [VW-1:0] resp_vec;
    logic          busy;
    logic [DW-1:0] exp_operand;
    logic          exp_valid_in;
    logic          exp_ready_in = 1'b0;
    logic [DW-1:0] exp_result = '0;
    logic          exp_valid_out = 1'b0;
    logic          exp_ready_out;

    vexp_sequencer dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec), .req_len(req_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_vec(resp_vec), .busy(busy),
        .exp_operand(exp_operand), .exp_valid_in(exp_valid_in), .exp_ready_in(exp_ready_in),
        .exp_result(exp_result), .exp_valid_out(exp_valid_out), .exp_ready_out(exp_ready_out)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, want);
        end
    endtask

    function automatic logic [DW-1:0] vexp_f(input logic [DW-1:0] x);
        return x * 16'd3 + 16'h1234;
    endfunction

    function automatic logic [VW-1:0] ref_resp(input logic [VW-1:0] v, input int len);
        logic [VW-1:0] r;
        int n;
        n = (len > NE) ? NE : len;
        r = '0;
        for (int i = 0; i < NE; i++) begin
            if (i < n) r[i*DW +: DW] = vexp_f(v[i*DW +: DW]);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] r;
        for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // scoreboard: expected vector, expected issue count, expected resp latency (-1 = unchecked)
    logic [VW-1:0] sb_vec[$];
    int            sb_len[$];
    int            sb_lat[$];

    // vexp unit model: fixed latency, in order, optional random operand backpressure
    int            lat_g   = 1;
    int            rdy_pct = 100;
    int            pend_due[$];
    logic [DW-1:0] pend_val[$];

    always @(negedge CLK) begin
        if (!nRST) begin
            pend_due.delete();
            pend_val.delete();
            exp_valid_out = 1'b0;
            exp_result    = '0;
            exp_ready_in  = 1'b0;
        end else begin
            exp_ready_in = ($urandom_range(99) < rdy_pct);
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                exp_valid_out = 1'b1;
                exp_result    = pend_val[0];
            end else begin
                exp_valid_out = 1'b0;
                exp_result    = '0;
            end
            #1;
            if (nRST) begin
                if (exp_valid_out && exp_ready_out) begin
                    pend_due.delete(0);
                    pend_val.delete(0);
                end
                if (exp_valid_in && exp_ready_in) begin
                    pend_due.push_back(cyc + lat_g);
                    pend_val.push_back(vexp_f(exp_operand));
                end
            end
        end
    end

    // monitor
    int            acc_edge = 0;
    int            iss_n = 0;
    int            out_n = 0;
    int            resp_n = 0;
    logic [VW-1:0] cur_vec = '0;
    bit            pv_valid = 0, pv_rdy = 0, pr_valid = 0, pr_rdy = 0;
    logic [DW-1:0] pv_op = '0;
    logic [VW-1:0] pr_vec = '0;

    always @(negedge CLK) begin
        #2;
        if (!nRST) begin
            iss_n    = 0;
            out_n    = 0;
            pv_valid = 0;
            pr_valid = 0;
        end else begin
            if (exp_valid_in) begin
                chk("credit", VW'(out_n < 4), VW'(1));
                chk("operand", exp_operand, cur_vec[iss_n*DW +: DW]);
            end else if (busy) begin
                chk("operand_idle", exp_operand, '0);
            end
            if (resp_valid || !busy) chk("issue_quiet", exp_valid_in, '0);
            if (pv_valid && !pv_rdy) begin
                chk("valid_hold", exp_valid_in, VW'(1));
                chk("operand_hold", exp_operand, pv_op);
            end
            chk("ret_ready", exp_ready_out, VW'(out_n != 0));
            pv_valid = exp_valid_in;
            pv_rdy   = exp_ready_in;
            pv_op    = exp_operand;
            if (exp_valid_in && exp_ready_in) begin
                iss_n++;
                out_n++;
            end
            if (exp_valid_out && exp_ready_out) out_n--;
            if (resp_valid) begin
                chk("req_ready_done", req_ready, '0);
                if (!pr_valid && sb_lat.size() > 0 && sb_lat[0] >= 0)
                    chk("resp_latency", VW'(cyc + 1 - acc_edge), VW'(sb_lat[0]));
                if (pr_valid && !pr_rdy) chk("resp_hold", resp_vec, pr_vec);
                if (resp_ready) begin
                    if (sb_vec.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp: got=%0h want=none", resp_vec);
                    end else begin
                        chk("resp_vec", resp_vec, sb_vec.pop_front());
                        chk("issue_count", VW'(iss_n), VW'(sb_len.pop_front()));
                        sb_lat.delete(0);
                    end
                    resp_n++;
                end
            end
            pr_valid = resp_valid;
            pr_rdy   = resp_ready;
            pr_vec   = resp_vec;
            if (req_valid && req_ready) begin
                acc_edge = cyc + 1;
                iss_n    = 0;
                cur_vec  = req_vec;
            end
        end
    end

    int n_exp = 0;

    task automatic push_exp(input int len, input logic [VW-1:0] v, input bit tchk);
        int n;
        n = (len > NE) ? NE : len;
        sb_vec.push_back(ref_resp(v, len));
        sb_len.push_back(n);
        sb_lat.push_back(tchk ? ((n == 0) ? 1 : n + lat_g + 1) : -1);
    endtask

    // called at a negedge with req_valid already high; returns at the negedge after acceptance
    task automatic wait_accept();
        int t;
        t = 0;
        #1;
        while (!req_ready && t < 300) begin
            @(negedge CLK);
            #1;
            t++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got=req_ready_low want=accept");
        end
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic send(input int len, input logic [VW-1:0] v, input bit tchk);
        push_exp(len, v, tchk);
        @(negedge CLK);
        req_valid = 1'b1;
        req_vec   = v;
        req_len   = 5'(len);
        wait_accept();
    endtask

    task automatic wait_resp(input int target);
        for (int t = 0; t < 3000 && resp_n < target; t++) @(negedge CLK);
        if (resp_n < target) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got=%0d want=%0d", resp_n, target);
        end
    endtask

    task automatic reset_checks();
        chk("rst_req_ready", req_ready, VW'(1));
        chk("rst_resp_valid", resp_valid, '0);
        chk("rst_busy", busy, '0);
        chk("rst_valid_in", exp_valid_in, '0);
        chk("rst_operand", exp_operand, '0);
        chk("rst_ready_out", exp_ready_out, '0);
        chk("rst_resp_vec", resp_vec, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VW-1:0] v, v2;
        repeat (2) @(negedge CLK);
        #1;
        reset_checks();
        @(negedge CLK);
        nRST = 1'b1;

        // 1: full vector, latency 3, always ready
        lat_g = 3; rdy_pct = 100;
        v = {NE{16'h3F80}};
        send(16, v, 1'b1); n_exp++; wait_resp(n_exp);

        // 2: short vector, elements 0..4, remaining slots must come back zero
        lat_g = 2;
        v = rvec();
        for (int i = 0; i < 5; i++) v[i*DW +: DW] = 16'(i);
        send(5, v, 1'b1); n_exp++; wait_resp(n_exp);

        // 3: empty vector, then oversize length clamped to NE
        send(0, rvec(), 1'b1); n_exp++; wait_resp(n_exp);
        lat_g = 1;
        send(20, rvec(), 1'b1); n_exp++; wait_resp(n_exp);

        // 4: long latency with random operand backpressure
        lat_g = 8; rdy_pct = 50;
        for (int k = 0; k < 3; k++) begin
            send(int'($urandom_range(1, 31)), rvec(), 1'b0); n_exp++; wait_resp(n_exp);
        end

        // 5: stall the response while a second request is held pending
        lat_g = 1; rdy_pct = 100; resp_ready = 1'b0;
        v = rvec(); v2 = rvec();
        push_exp(2, v, 1'b1);
        push_exp(3, v2, 1'b1);
        @(negedge CLK);
        req_valid = 1'b1; req_vec = v; req_len = 5'd2;
        wait_accept();
        req_valid = 1'b1; req_vec = v2; req_len = 5'd3;
        for (int t = 0; t < 100 && !resp_valid; t++) @(negedge CLK);
        repeat (10) @(negedge CLK);
        resp_ready = 1'b1;
        @(negedge CLK);
        #1;
        chk("idle_after_resp_ready", req_ready, VW'(1));
        chk("idle_after_resp_busy", busy, '0);
        n_exp++;
        wait_accept();
        n_exp++; wait_resp(n_exp);

        // 6: reset mid-run after 7 issues, then a clean short request
        lat_g = 3; rdy_pct = 100;
        send(16, rvec(), 1'b1);
        for (int t = 0; t < 200 && iss_n < 7; t++) @(negedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        reset_checks();
        sb_vec.delete(); sb_len.delete(); sb_lat.delete();
        @(negedge CLK);
        #4;
        nRST = 1'b1;
        send(3, rvec(), 1'b1); n_exp++; wait_resp(n_exp);

        repeat (5) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
